// File: rtl/rate_timer.sv
// Programmable-rate strobe timer with IDLE/RUN/HOLD control and a wrapping strobe counter.
// Optional runtime limit load is compiled in with the RATE_TIMER_LOAD_EN macro.
module rate_timer #(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned NB_SEL     = 2,
  parameter int unsigned BASE_SHIFT = 10,
  parameter int unsigned NB_TICKS   = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_mode,
  input  logic                  i_start,
  input  logic [NB_SEL-1:0]     i_sel,
`ifdef RATE_TIMER_LOAD_EN
  input  logic                  i_load,
  input  logic [NB_COUNTER-1:0] i_limit,
`endif
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [NB_TICKS-1:0]   o_ticks
);

  localparam int unsigned NbEntries = 2 ** NB_SEL;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e                state_q, state_d;
  logic [NB_COUNTER-1:0] count_q, count_d;
  logic                  mode_q, mode_d;
  logic [NB_SEL-1:0]     sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [NB_TICKS-1:0]   ticks_q, ticks_d;

  logic [NB_COUNTER-1:0] table_limit;
  logic [NB_COUNTER-1:0] limit;
  logic                  clear;

  // Entry k of the rate table is 2**(NB_COUNTER-BASE_SHIFT-k)-1.
  always_comb begin
    table_limit = '0;
    for (int unsigned k = 0; k < NbEntries; k++) begin
      if (sel_q == NB_SEL'(k)) begin
        table_limit = (NB_COUNTER'(1) << (NB_COUNTER - BASE_SHIFT - k)) - NB_COUNTER'(1);
      end
    end
  end

`ifdef RATE_TIMER_LOAD_EN
  logic [NB_COUNTER-1:0] limit_q, limit_d;
  logic                  ovr_q, ovr_d;

  always_comb begin
    limit_d = limit_q;
    ovr_d   = ovr_q;
    if (i_load) begin
      limit_d = i_limit;
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      limit_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      ovr_q   <= ovr_d;
    end
  end

  assign limit = ovr_q ? limit_q : table_limit;
  assign clear = (i_sel != sel_q) || i_load;
`else
  assign limit = table_limit;
  assign clear = (i_sel != sel_q);
`endif

  // HOLD behaves as a paused RUN: a cycle with enable high counts from either state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    sel_d   = i_sel;
    valid_d = 1'b0;
    ticks_d = ticks_q;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (i_enable && (!i_mode || i_start)) begin
          state_d = StRun;
          mode_d  = i_mode;
        end
      end
      StRun, StHold: begin
        state_d = i_enable ? StRun : StHold;
        if (clear) begin
          count_d = '0;
        end else if (i_enable) begin
          if (count_q >= limit) begin
            count_d = '0;
            valid_d = 1'b1;
            ticks_d = ticks_q + NB_TICKS'(1);
            if (mode_q) begin
              state_d = StIdle;
            end
          end else begin
            count_d = count_q + NB_COUNTER'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ticks_q <= ticks_d;
    end
  end

  assign o_valid = valid_q;
  assign o_busy  = (state_q != StIdle);
  assign o_ticks = ticks_q;

endmodule

// File: tb/tb_rate_timer.sv
// Self-checking bench for rate_timer: directed scenarios plus random stimulus against a
// period-countdown reference model.
module tb_rate_timer;
  localparam int NbCounter = 14;
  localparam int NbSel     = 2;
  localparam int BaseShift = 10;
  localparam int NbTicks   = 8;

  logic                 clock = 1'b0;
  logic                 i_reset;
  logic                 i_enable;
  logic                 i_mode;
  logic                 i_start;
  logic [NbSel-1:0]     i_sel;
`ifdef RATE_TIMER_LOAD_EN
  logic                 i_load;
  logic [NbCounter-1:0] i_limit;
`endif
  logic                 o_valid;
  logic                 o_busy;
  logic [NbTicks-1:0]   o_ticks;

  rate_timer #(
    .NB_COUNTER (NbCounter),
    .NB_SEL     (NbSel),
    .BASE_SHIFT (BaseShift),
    .NB_TICKS   (NbTicks)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .i_start  (i_start),
    .i_sel    (i_sel),
`ifdef RATE_TIMER_LOAD_EN
    .i_load   (i_load),
    .i_limit  (i_limit),
`endif
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_ticks  (o_ticks)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles remaining until the next strobe while a period is in progress.
  bit m_active, m_mode, m_valid, m_ovr;
  int m_sel, m_rem, m_ticks, m_lim_ovr;

  function automatic int table_lim(input int k);
    return (1 << (NbCounter - BaseShift - k)) - 1;
  endfunction

  function automatic int cur_lim();
    return m_ovr ? m_lim_ovr : table_lim(m_sel);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_mode    = 1'b0;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    m_sel     = 0;
    m_rem     = 0;
    m_ticks   = 0;
    m_lim_ovr = 0;
  endtask

  task automatic model_step();
    bit reload;
    int new_sel;
    bit ld;
    ld = 1'b0;
`ifdef RATE_TIMER_LOAD_EN
    if (i_load) begin
      ld        = 1'b1;
      m_ovr     = 1'b1;
      m_lim_ovr = int'(i_limit);
    end
`endif
    new_sel = int'(i_sel);
    reload  = (new_sel != m_sel) || ld;
    m_sel   = new_sel;
    m_valid = 1'b0;
    if (!m_active) begin
      if (i_enable && (!i_mode || i_start)) begin
        m_active = 1'b1;
        m_mode   = i_mode;
        m_rem    = cur_lim() + 1;
      end
    end else if (reload) begin
      m_rem = cur_lim() + 1;
    end else if (i_enable) begin
      m_rem--;
      if (m_rem == 0) begin
        m_valid = 1'b1;
        m_ticks = (m_ticks + 1) % (1 << NbTicks);
        m_rem   = cur_lim() + 1;
        if (m_mode) m_active = 1'b0;
      end
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare #1 later.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_val("valid", 32'(o_valid), 32'(m_valid));
    check_val("busy", 32'(o_busy), 32'(m_active));
    check_val("ticks", 32'(o_ticks), 32'(m_ticks));
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_mode   = 1'b0;
    i_start  = 1'b0;
    i_sel    = '0;
`ifdef RATE_TIMER_LOAD_EN
    i_load   = 1'b0;
    i_limit  = '0;
`endif
    model_reset();
    #1;
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_ticks", 32'(o_ticks), 32'd0);
    @(negedge clock);
    i_reset = 1'b1;
  endtask

  initial begin
    int first;
    int strobes;
    i_reset = 1'b0;
    do_reset();

    // Continuous, table entry 2 (limit 3): strobe every 4 cycles.
    i_sel    = 2'd2;
    i_enable = 1'b1;
    i_mode   = 1'b0;
    cycle();
    check_val("cont_busy", 32'(o_busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check_val("cont_strobe", 32'(o_valid), 32'((k % 4) == 0));
      check_val("cont_ticks", 32'(o_ticks), 32'(k / 4));
    end

    // One-shot, limit 1, with a retrigger attempt during RUN.
    do_reset();
    i_sel    = 2'd3;
    i_enable = 1'b1;
    i_mode   = 1'b1;
    i_start  = 1'b1;
    cycle();
    cycle();
    check_val("os_early", 32'(o_valid), 32'd0);
    i_start = 1'b0;
    cycle();
    check_val("os_strobe", 32'(o_valid), 32'd1);
    check_val("os_idle", 32'(o_busy), 32'd0);
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      strobes += int'(o_valid);
    end
    check_val("os_single", 32'(strobes), 32'd0);

    // Pause for 10 cycles at count 5 with limit 15.
    do_reset();
    i_enable = 1'b1;
    cycle();
    first = -1;
    for (int e = 1; e <= 40; e++) begin
      i_enable = !(e >= 6 && e <= 15);
      cycle();
      if (o_valid && first < 0) first = e;
    end
    check_val("hold_delay", 32'(first), 32'd26);

    // Select change mid-period, then a change coinciding with the terminal count.
    do_reset();
    i_enable = 1'b1;
    cycle();
    for (int e = 1; e <= 34; e++) begin
      if (e == 10) i_sel = 2'd1;
      if (e == 26) i_sel = 2'd2;
      cycle();
      if (e == 17) check_val("sel_pre", 32'(o_valid), 32'd0);
      if (e == 18) check_val("sel_strobe", 32'(o_valid), 32'd1);
      if (e == 26) check_val("sel_suppress", 32'(o_valid), 32'd0);
      if (e == 30) check_val("sel_next", 32'(o_valid), 32'd1);
    end

    // Asynchronous reset between clock edges while running.
    do_reset();
    i_sel    = 2'd3;
    i_enable = 1'b1;
    for (int k = 0; k < 7; k++) cycle();
    #2;
    i_reset = 1'b0;
    #1;
    check_val("async_valid", 32'(o_valid), 32'd0);
    check_val("async_busy", 32'(o_busy), 32'd0);
    check_val("async_ticks", 32'(o_ticks), 32'd0);
    model_reset();
    @(negedge clock);
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    // 256 strobes at limit 1 wrap the tick counter.
    do_reset();
    i_sel    = 2'd3;
    i_enable = 1'b1;
    cycle();
    strobes = 0;
    for (int e = 1; e <= 512; e++) begin
      cycle();
      strobes += int'(o_valid);
      if (e == 510) check_val("wrap_255", 32'(o_ticks), 32'd255);
    end
    check_val("wrap_count", 32'(strobes), 32'd256);
    check_val("wrap_zero", 32'(o_ticks), 32'd0);

`ifdef RATE_TIMER_LOAD_EN
    do_reset();
    i_enable = 1'b1;
    i_load   = 1'b1;
    i_limit  = 14'd5;
    cycle();
    i_load = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      check_val("load_strobe", 32'(o_valid), 32'((e % 6) == 0));
    end
`endif

    // Random stimulus against the model, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((n % 700) == 699) do_reset();
      i_enable = ($urandom_range(0, 9) != 0);
      i_mode   = 1'($urandom_range(0, 1));
      i_start  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) i_sel = 2'($urandom_range(0, 3));
`ifdef RATE_TIMER_LOAD_EN
      i_load  = ($urandom_range(0, 79) == 0);
      i_limit = 14'($urandom_range(0, 20));
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
